// File: rtl/reset_request_generator.sv
// reset_request_generator
//   Produces one clean, fixed-width, active-high reset request pulse for the
//   reset synchronizer. The request comes from either the bouncy board button
//   or a one-cycle soft request from game logic. Debounce, pulse width,
//   holdoff and a wait for button release together give exactly one request
//   per press.
//
// Ports
//   clk        system clock (only clock)
//   reset      synchronous, active-high reset
//   btn_raw    raw reset button, asynchronous and bouncy, active-high
//   soft_req   one-cycle synchronous request from game logic
//   rst_req    registered reset request pulse, active-high
//   busy       registered, high whenever the FSM is not in IDLE
//   req_count  number of pulses issued, saturating at 255
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for soft_req or a high synchronized button sample
// DEBOUNCE | counting consecutive high button samples
// ASSERT   | driving rst_req high for PULSE_CYCLES cycles
// HOLDOFF  | rst_req low, all requests ignored for HOLDOFF_CYCLES cycles
// RELEASE  | waiting for the button to be released before re-arming

module reset_request_generator #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 8,
  parameter int HOLDOFF_CYCLES  = 32,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       soft_req,
  output logic       rst_req,
  output logic       busy,
  output logic [7:0] req_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_ASSERT   = 3'd2,
    ST_HOLDOFF  = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  // Terminal counts: the counter starts at 0 (or 1 in DEBOUNCE, where the
  // first high sample was already seen in IDLE) and the state is left when
  // the counter equals the last index.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PUL_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ff1;
  logic             btn_s;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (soft_req) begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
        end else if (btn_s) begin
          // This sample is already high sample number one.
          if (DEBOUNCE_CYCLES == 1) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
          end else begin
            state_next = ST_DEBOUNCE;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      ST_DEBOUNCE: begin
        if (soft_req) begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
        end else if (!btn_s) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_ASSERT: begin
        if (cnt == PUL_LAST) begin
          state_next = ST_HOLDOFF;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_next = ST_RELEASE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!btn_s) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ff1       <= 1'b0;
      btn_s     <= 1'b0;
      rst_req   <= 1'b0;
      busy      <= 1'b0;
      req_count <= 8'd0;
    end else begin
      ff1     <= btn_raw;
      btn_s   <= ff1;
      state   <= state_next;
      cnt     <= cnt_next;
      // Outputs are decoded from the next state so they change on the same
      // edge as the state register.
      rst_req <= (state_next == ST_ASSERT);
      busy    <= (state_next != ST_IDLE);
      if ((state_next == ST_ASSERT) && (state != ST_ASSERT) && (req_count != 8'hFF)) begin
        req_count <= req_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reset_request_generator.sv
module tb_reset_request_generator;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       soft_req;
  logic       rst_req;
  logic       busy;
  logic [7:0] req_count;

  int n_cmp = 0;
  int n_bad = 0;

  reset_request_generator #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (8),
    .HOLDOFF_CYCLES (32),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .soft_req (soft_req),
    .rst_req  (rst_req),
    .busy     (busy),
    .req_count(req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       b;
    logic       s;
    logic       e_rst;
    logic       e_busy;
    logic [7:0] e_cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic b, input logic s,
                              input logic er, input logic eb, input logic [7:0] ec,
                              input string nm);
    vec_t v;
    v.r = r; v.b = b; v.s = s;
    v.e_rst = er; v.e_busy = eb; v.e_cnt = ec; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic s);
    reset    = r;
    btn_raw  = b;
    soft_req = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input logic er, input logic eb, input logic [7:0] ec);
    check({nm, ".rst_req"}, int'(rst_req), int'(er));
    check({nm, ".busy"}, int'(busy), int'(eb));
    check({nm, ".req_count"}, int'(req_count), int'(ec));
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].r, vecs[i].b, vecs[i].s);
      check_out(vecs[i].name, vecs[i].e_rst, vecs[i].e_busy, vecs[i].e_cnt);
    end
  endtask

  initial begin
    int press_lo, press_hi, bounce_lo, bounce_hi;
    int high_cnt;
    logic [7:0] exp_cnt;

    reset    = 1'b1;
    btn_raw  = 1'b1;
    soft_req = 1'b1;

    // Reset held 3 cycles with both request sources active.
    add(1, 1, 1, 0, 0, 8'd0, "reset0");
    add(1, 1, 1, 0, 0, 8'd0, "reset1");
    add(1, 1, 1, 0, 0, 8'd0, "reset2");
    // Clean press: button held from edge 0 after reset release.
    press_lo = vecs.size();
    add(0, 1, 0, 0, 0, 8'd0, "press_e0");
    add(0, 1, 0, 0, 0, 8'd0, "press_e1");
    add(0, 1, 0, 0, 1, 8'd0, "press_e2");
    add(0, 1, 0, 0, 1, 8'd0, "press_e3");
    add(0, 1, 0, 0, 1, 8'd0, "press_e4");
    for (int e = 5; e <= 12; e++) add(0, 1, 0, 1, 1, 8'd1, $sformatf("press_e%0d", e));
    add(0, 1, 0, 0, 1, 8'd1, "press_e13");
    press_hi = vecs.size() - 1;
    // Bounce: 1,1,0,1,1,1 then low; never reaches 4 consecutive samples.
    bounce_lo = vecs.size();
    add(0, 1, 0, 0, 0, 8'd1, "bounce_e0");
    add(0, 1, 0, 0, 0, 8'd1, "bounce_e1");
    add(0, 0, 0, 0, 1, 8'd1, "bounce_e2");
    add(0, 1, 0, 0, 1, 8'd1, "bounce_e3");
    add(0, 1, 0, 0, 0, 8'd1, "bounce_e4");
    add(0, 1, 0, 0, 1, 8'd1, "bounce_e5");
    add(0, 0, 0, 0, 1, 8'd1, "bounce_e6");
    add(0, 0, 0, 0, 1, 8'd1, "bounce_e7");
    add(0, 0, 0, 0, 0, 8'd1, "bounce_e8");
    add(0, 0, 0, 0, 0, 8'd1, "bounce_e9");
    bounce_hi = vecs.size() - 1;

    run_vectors(0, press_hi);

    // Button still held: holdoff through edge 44, then stuck in RELEASE.
    for (int e = 14; e <= 60; e++) begin
      step(0, 1, 0);
      check_out($sformatf("held_e%0d", e), 1'b0, 1'b1, 8'd1);
    end
    // Release: two sync stages then the FSM sees btn_s low.
    step(0, 0, 0); check_out("release_e61", 1'b0, 1'b1, 8'd1);
    step(0, 0, 0); check_out("release_e62", 1'b0, 1'b1, 8'd1);
    step(0, 0, 0); check_out("release_e63", 1'b0, 1'b0, 8'd1);
    step(0, 0, 0); check_out("release_e64", 1'b0, 1'b0, 8'd1);

    run_vectors(bounce_lo, bounce_hi);

    // Soft request at rel 0; extra requests at rel 4 (ASSERT) and 20 (HOLDOFF)
    // are dropped. IDLE again after rel 41.
    for (int e = 0; e <= 41; e++) begin
      step(0, 0, (e == 0 || e == 4 || e == 20));
      check_out($sformatf("soft_e%0d", e), (e <= 7), (e <= 40), 8'd2);
    end

    // Second soft pulse, then reset on its third high cycle.
    step(0, 0, 1); check_out("soft2_e42", 1'b1, 1'b1, 8'd3);
    step(0, 0, 0); check_out("soft2_e43", 1'b1, 1'b1, 8'd3);
    step(0, 0, 0); check_out("soft2_e44", 1'b1, 1'b1, 8'd3);
    step(1, 0, 0); check_out("midreset_e45", 1'b0, 1'b0, 8'd0);
    for (int e = 0; e < 12; e++) begin
      step(0, 0, 0);
      check_out($sformatf("after_reset_%0d", e), 1'b0, 1'b0, 8'd0);
    end

    // Saturation: 257 soft requests spaced 42 cycles apart.
    for (int k = 1; k <= 257; k++) begin
      exp_cnt = (k > 255) ? 8'd255 : 8'(k);
      step(0, 0, 1);
      high_cnt = int'(rst_req);
      check($sformatf("sat%0d.req_count", k), int'(req_count), int'(exp_cnt));
      for (int i = 1; i <= 7; i++) begin
        step(0, 0, 0);
        high_cnt += int'(rst_req);
      end
      step(0, 0, 0);
      check($sformatf("sat%0d.pulse_width", k), high_cnt, 8);
      check($sformatf("sat%0d.pulse_end", k), int'(rst_req), 0);
      for (int i = 9; i <= 41; i++) step(0, 0, 0);
      check($sformatf("sat%0d.idle_busy", k), int'(busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
